// File: rtl/multiword_adder_sequencer_pkg.sv
// Shared definitions for the multi-word adder sequencer.
//   state_e : FSM state encoding (IDLE=0, RUN=1, DONE=2)
//   clog2   : width of the slice index for a given slice count
package multiword_adder_sequencer_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Minimum number of bits needed to index n items (n >= 2).
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((32'(1) << r) < n) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/carry_forecast.sv
// Carry lookahead for one slice: predicts the carry out of a + b + cin
// from group generate/propagate terms without forming the sum.
// Ports:
//   i_a, i_b      : slice operands
//   i_carry_in    : carry into the slice
//   o_carry_out   : predicted carry out of the slice MSB
//   o_and_result  : bitwise generate vector (a & b)
module carry_forecast #(
    parameter int unsigned BIT_WIDTH = 4
) (
    input  logic [BIT_WIDTH-1:0] i_a,
    input  logic [BIT_WIDTH-1:0] i_b,
    input  logic                 i_carry_in,
    output logic                 o_carry_out,
    output logic [BIT_WIDTH-1:0] o_and_result
);

    logic [BIT_WIDTH-1:0] w_gen;
    logic [BIT_WIDTH-1:0] w_prop;
    logic                 w_grp_gen;
    logic                 w_grp_prop;

    assign w_gen        = i_a & i_b;
    assign w_prop       = i_a | i_b;
    assign o_and_result = w_gen;

    // Fold bit generate/propagate into a single group term, LSB upward.
    always_comb begin
        w_grp_gen  = 1'b0;
        w_grp_prop = 1'b1;
        for (int i = 0; i < int'(BIT_WIDTH); i++) begin
            w_grp_gen  = w_gen[i] | (w_prop[i] & w_grp_gen);
            w_grp_prop = w_grp_prop & w_prop[i];
        end
    end

    assign o_carry_out = w_grp_gen | (w_grp_prop & i_carry_in);

endmodule

// File: rtl/multiword_adder_sequencer.sv
// Multi-cycle wide adder: computes op1 + op2 + cin one BIT_WIDTH slice per
// clock, LSB slice first, with the inter-slice carry taken from a lookahead
// forecast.
// Ports:
//   i_clock, i_reset_n            : clock, async active-low reset
//   i_start_valid / o_start_ready : command handshake
//   i_operand1, i_operand2        : operands, sampled on accept
//   i_carry_in                    : input carry, sampled on accept
//   o_result_valid/i_result_ready : result handshake
//   o_sum, o_carry_out, o_overflow: registered result
//   o_busy                        : high while RUN or DONE
module multiword_adder_sequencer
    import multiword_adder_sequencer_pkg::*;
#(
    parameter int unsigned BIT_WIDTH       = 4,
    parameter int unsigned NUMBER_OF_SLICE = 4
) (
    input  logic                                 i_clock,
    input  logic                                 i_reset_n,
    input  logic                                 i_start_valid,
    output logic                                 o_start_ready,
    input  logic [BIT_WIDTH*NUMBER_OF_SLICE-1:0] i_operand1,
    input  logic [BIT_WIDTH*NUMBER_OF_SLICE-1:0] i_operand2,
    input  logic                                 i_carry_in,
    output logic                                 o_result_valid,
    input  logic                                 i_result_ready,
    output logic [BIT_WIDTH*NUMBER_OF_SLICE-1:0] o_sum,
    output logic                                 o_carry_out,
    output logic                                 o_overflow,
    output logic                                 o_busy
);

    localparam int unsigned W     = BIT_WIDTH * NUMBER_OF_SLICE;
    localparam int unsigned IDX_W = clog2(NUMBER_OF_SLICE);

    state_e             r_state;
    state_e             w_state_next;
    logic [IDX_W-1:0]   r_idx;
    logic [W-1:0]       r_op1;
    logic [W-1:0]       r_op2;
    logic               r_carry;
    logic [W-1:0]       r_sum;
    logic               r_cout;
    logic               r_ovf;

    logic               w_accept;
    logic               w_step;
    logic               w_last;
    logic [BIT_WIDTH-1:0] w_a;
    logic [BIT_WIDTH-1:0] w_b;
    logic [BIT_WIDTH:0]   w_slice_sum;
    logic                 w_fc_carry;
    logic [BIT_WIDTH-1:0] w_fc_and;

    assign w_a         = r_op1[r_idx*BIT_WIDTH +: BIT_WIDTH];
    assign w_b         = r_op2[r_idx*BIT_WIDTH +: BIT_WIDTH];
    assign w_slice_sum = {1'b0, w_a} + {1'b0, w_b} + {{BIT_WIDTH{1'b0}}, r_carry};
    assign w_last      = (r_idx == IDX_W'(NUMBER_OF_SLICE - 1));

    carry_forecast #(
        .BIT_WIDTH (BIT_WIDTH)
    ) u_carry_forecast (
        .i_a          (w_a),
        .i_b          (w_b),
        .i_carry_in   (r_carry),
        .o_carry_out  (w_fc_carry),
        .o_and_result (w_fc_and)
    );

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_accept       = 1'b0;
        w_step         = 1'b0;
        o_start_ready  = 1'b0;
        o_result_valid = 1'b0;
        o_busy         = 1'b0;
        unique case (r_state)
            StIdle: begin
                o_start_ready = 1'b1;
                if (i_start_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = StRun;
                end
            end
            StRun: begin
                o_busy = 1'b1;
                w_step = 1'b1;
                if (w_last) begin
                    w_state_next = StDone;
                end
            end
            StDone: begin
                o_busy         = 1'b1;
                o_result_valid = 1'b1;
                if (i_result_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_idx   <= '0;
            r_op1   <= '0;
            r_op2   <= '0;
            r_carry <= 1'b0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_op1   <= i_operand1;
            r_op2   <= i_operand2;
            r_carry <= i_carry_in;
            r_idx   <= '0;
        end else if (w_step) begin
            r_sum[r_idx*BIT_WIDTH +: BIT_WIDTH] <= w_slice_sum[BIT_WIDTH-1:0];
            r_carry <= w_fc_carry;
            r_idx   <= w_last ? '0 : r_idx + 1'b1;
            if (w_last) begin
                r_cout <= w_fc_carry;
                // Slice MSB here is the word MSB of the new sum.
                r_ovf  <= (r_op1[W-1] == r_op2[W-1]) &&
                          (w_slice_sum[BIT_WIDTH-1] != r_op1[W-1]);
            end
        end
    end

    assign o_sum       = r_sum;
    assign o_carry_out = r_cout;
    assign o_overflow  = r_ovf;

    a_forecast_matches: assert property (@(posedge i_clock) disable iff (!i_reset_n)
        (r_state == StRun) |-> (w_fc_carry == w_slice_sum[BIT_WIDTH]));

    a_and_matches: assert property (@(posedge i_clock) disable iff (!i_reset_n)
        (r_state == StRun) |-> (w_fc_and == (w_a & w_b)));

endmodule

// File: tb/tb_multiword_adder_sequencer.sv
module tb_multiword_adder_sequencer;

    logic        clk;
    logic        reset_n;
    logic        start_valid;
    logic        start_ready;
    logic [15:0] op1;
    logic [15:0] op2;
    logic        cin;
    logic        result_valid;
    logic        result_ready;
    logic [15:0] sum;
    logic        carry_out;
    logic        overflow;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Expected {overflow, carry_out, sum}
    logic [17:0] sb[$];

    multiword_adder_sequencer #(
        .BIT_WIDTH       (4),
        .NUMBER_OF_SLICE (4)
    ) dut (
        .i_clock        (clk),
        .i_reset_n      (reset_n),
        .i_start_valid  (start_valid),
        .o_start_ready  (start_ready),
        .i_operand1     (op1),
        .i_operand2     (op2),
        .i_carry_in     (cin),
        .o_result_valid (result_valid),
        .i_result_ready (result_ready),
        .o_sum          (sum),
        .o_carry_out    (carry_out),
        .o_overflow     (overflow),
        .o_busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic c);
        int u;
        int s;
        int sa;
        int sb_v;
        logic [16:0] full;
        logic ovf;
        u    = int'(a) + int'(b) + int'(c);
        sa   = int'($signed(a));
        sb_v = int'($signed(b));
        s    = sa + sb_v + int'(c);
        full = u[16:0];
        ovf  = (s > 32767) || (s < -32768);
        return {ovf, full[16], full[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result monitor: a handshake completes on the next edge.
    initial begin
        logic [17:0] e;
        forever begin
            @(negedge clk);
            if (reset_n && result_valid && result_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result: got sum %h with no command pending", sum);
                end else begin
                    e = sb.pop_front();
                    check("sum", 32'(sum), 32'(e[15:0]));
                    check("carry_out", 32'(carry_out), 32'(e[16]));
                    check("overflow", 32'(overflow), 32'(e[17]));
                end
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic c,
                        input bit keep, output int acc);
        int n;
        n           = 0;
        op1         = a;
        op2         = b;
        cin         = c;
        start_valid = 1'b1;
        @(negedge clk);
        while (!start_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        acc = cyc;
        if (!start_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got start_ready 0 expected 1");
        end else begin
            sb.push_back(model(a, b, c));
        end
        @(posedge clk);
        #1;
        if (!keep) start_valid = 1'b0;
    endtask

    // Returns edges elapsed since accept until result_valid, then lets it drain.
    task automatic wait_result(output int n);
        n = 0;
        while (!result_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!result_valid) begin
            checks++;
            errors++;
            $display("FAIL result_timeout: got result_valid 0 expected 1");
        end
        while (result_valid && result_ready) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int prev;
        int n;
        logic [17:0] e;
        logic [15:0] a;
        logic [15:0] b;
        logic c;

        reset_n      = 1'b0;
        start_valid  = 1'b0;
        op1          = '0;
        op2          = '0;
        cin          = 1'b0;
        result_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_sum", 32'(sum), 32'h0);
        check("rst_cout", 32'(carry_out), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        check("rst_valid", 32'(result_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_ready", 32'(start_ready), 32'h1);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // Carry out of the full word; latency check.
        send(16'hFFFF, 16'h0001, 1'b0, 1'b0, acc);
        check("busy_run", 32'(busy), 32'h1);
        wait_result(n);
        check("latency", 32'(n), 32'd4);

        send(16'h7FFF, 16'h0001, 1'b0, 1'b0, acc);
        wait_result(n);
        send(16'h8000, 16'h8000, 1'b0, 1'b0, acc);
        wait_result(n);

        // start_valid during RUN must be ignored.
        send(16'h1234, 16'h4321, 1'b1, 1'b0, acc);
        op1         = 16'hAAAA;
        op2         = 16'h5555;
        start_valid = 1'b1;
        @(negedge clk);
        check("ready_in_run", 32'(start_ready), 32'h0);
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        wait_result(n);
        repeat (8) @(posedge clk);
        #1;
        check("no_extra_result", 32'(result_valid), 32'h0);
        check("idle_after_ignore", 32'(start_ready), 32'h1);

        // Backpressure in DONE.
        result_ready = 1'b0;
        e = model(16'hABCD, 16'h9876, 1'b1);
        send(16'hABCD, 16'h9876, 1'b1, 1'b0, acc);
        wait_result(n);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_valid", 32'(result_valid), 32'h1);
            check("bp_start_ready", 32'(start_ready), 32'h0);
            check("bp_sum", 32'(sum), 32'(e[15:0]));
            check("bp_cout", 32'(carry_out), 32'(e[16]));
            check("bp_ovf", 32'(overflow), 32'(e[17]));
        end
        @(posedge clk);
        #1;
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_valid", 32'(result_valid), 32'h0);
        check("bp_release_ready", 32'(start_ready), 32'h1);

        // Reset in the middle of RUN discards the operation.
        send(16'h1111, 16'h2222, 1'b0, 1'b0, acc);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(result_valid), 32'h0);
        check("mid_rst_ready", 32'(start_ready), 32'h1);
        check("mid_rst_busy", 32'(busy), 32'h0);
        sb.delete();
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        send(16'h0F0F, 16'h00F1, 1'b0, 1'b0, acc);
        wait_result(n);

        // Back-to-back random traffic.
        prev = 0;
        for (int i = 0; i < 10000; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            c = 1'($urandom);
            send(a, b, c, 1'b1, acc);
            if (i > 0 && (acc - prev) != 6) begin
                check("period", 32'(acc - prev), 32'd6);
            end else if (i > 0 && (i % 500) == 0) begin
                check("period", 32'(acc - prev), 32'd6);
            end
            prev = acc;
        end
        start_valid = 1'b0;
        n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multiword_adder_sequencer.md
Name: multiword_adder_sequencer

Overview:
Multi-cycle wide adder that computes op1 + op2 + cin on NUMBER_OF_SLICE*BIT_WIDTH-bit words, one BIT_WIDTH-bit slice per clock, LSB slice first. Each cycle, one carry_forecast instance predicts the carry into the next slice, so the slice adder never sees a long ripple chain. Uses valid/ready handshakes on the command and result sides, and sits between an operand source (ALU issue logic) and a result consumer.

Parameters:
BIT_WIDTH, 4, width of one slice; also the width of the carry_forecast instance.
NUMBER_OF_SLICE, 4, slices per word; word width is W = BIT_WIDTH*NUMBER_OF_SLICE. Must be at least 2.

Ports:
clock  input  1  single clock; all state updates on the rising edge.
reset_n  input  1  asynchronous, active-low reset.
start_valid  input  1  command offered.
start_ready  output  1  block can accept a command.
operand1  input  W  first operand, sampled on accept.
operand2  input  W  second operand, sampled on accept.
carry_in  input  1  input carry, sampled on accept.
result_valid  output  1  sum, carry_out and overflow are valid.
result_ready  input  1  consumer takes the result.
sum  output  W  registered word sum, mod 2^W.
carry_out  output  1  unsigned carry out of the word MSB.
overflow  output  1  two's-complement overflow.
busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, slice_index=0, operand and carry registers cleared.
  - Outputs: sum=0, carry_out=0, overflow=0, result_valid=0, busy=0, start_ready=1.
  - Takes effect immediately, including mid-RUN or in DONE; any in-flight operation is discarded and no result is produced for it.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid, latch operand1, operand2 and carry_in (carry register = carry_in), set slice_index=0, go to RUN.
- RUN:
  - start_ready=0; start_valid is ignored.
  - Slice k = bits [k*BIT_WIDTH +: BIT_WIDTH]. Each cycle, take slice k of both latched operands plus the carry register.
  - sum slice k <= low BIT_WIDTH bits of (a + b + carry).
  - Carry register <= carry_out of the carry_forecast instance fed with the same slices and carry.
  - slice_index increments by 1.
  - On the cycle slice_index = NUMBER_OF_SLICE-1:
    - carry_out <= the forecast.
    - overflow <= (op1[W-1] == op2[W-1]) && (new sum[W-1] != op1[W-1]).
    - Go to DONE.
- DONE:
  - result_valid=1; sum, carry_out and overflow stay stable until the handshake.
  - When result_ready=1, go to IDLE at the next edge; result_valid=0 from that edge.
  - result_valid does not depend combinationally on result_ready.
- Latency: accept edge at cycle 0; result_valid is first high at cycle NUMBER_OF_SLICE.
  - Back-to-back throughput with result_ready held high is one result per NUMBER_OF_SLICE+2 cycles.
- Outputs sum, carry_out and overflow keep the last result after returning to IDLE; they are overwritten slice by slice in the next RUN.
- The and_result output of carry_forecast is unused.
- Debug assertion: the forecast carry equals bit BIT_WIDTH of the full-width slice sum.

Decomposition:
- Shared package: FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), slice-index width function clog2(NUMBER_OF_SLICE).
- Sub-module: exactly one instance of carry_forecast #(.BIT_WIDTH(BIT_WIDTH)). All else is inline.

Test Plan:
BIT_WIDTH=4, NUMBER_OF_SLICE=4 (W=16) for all scenarios.
- 0xFFFF + 0x0001, cin=0 -> sum=0x0000, carry_out=1, overflow=0; result_valid high exactly 4 cycles after accept.
- 0x7FFF + 0x0001, cin=0 -> sum=0x8000, carry_out=0, overflow=1; 0x8000 + 0x8000 -> sum=0x0000, carry_out=1, overflow=1.
- 0x1234 + 0x4321, cin=1 -> sum=0x5556, carry_out=0, overflow=0; start_valid pulsed during RUN is ignored and start_ready stays 0.
- Backpressure: hold result_ready=0 for 5 cycles in DONE -> sum, carry_out and overflow stable, result_valid=1, start_ready=0. Raising result_ready -> IDLE next edge.
- Drop reset_n during RUN at slice_index=2 -> result_valid=0, start_ready=1 and busy=0 immediately. Next command 0x0F0F + 0x00F1 -> sum=0x1000, carry_out=0.
- Back-to-back random commands (10k, seeded) with result_ready=1 -> every result matches the reference model {carry,sum} = op1+op2+cin; accept-to-accept period = 6 cycles.
